// File: rtl/calc_core_pkg.sv
// Shared encodings for the calc core driver: core input modes, driver FSM states,
// request slot indices and command-word field offsets.
package calc_core_pkg;

   typedef enum logic [1:0] {
      IM_NOP   = 2'd0,
      IM_INPUT = 2'd1,
      IM_EXEC  = 2'd2,
      IM_REF   = 2'd3
   } inmode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_REARM = 2'd2
   } state_e;

   localparam int REQ_LD  = 0;
   localparam int REQ_RD  = 1;
   localparam int REQ_CMD = 2;

   // Command word is {mode, opr1_addr, opr2_addr, ret_addr}, MSB first.
   function automatic int cmd_mode_lsb(input int addr_w);
      return 3 * addr_w;
   endfunction

   function automatic int cmd_opr1_lsb(input int addr_w);
      return 2 * addr_w;
   endfunction

   function automatic int cmd_opr2_lsb(input int addr_w);
      return addr_w;
   endfunction

   function automatic int cmd_ret_lsb(input int addr_w);
      return 0 * addr_w;
   endfunction

endpackage

// File: rtl/calc_core_driver_if.sv
// Host-side request/response bundle of the calc core driver (load, readback,
// command and completion status).
interface calc_core_driver_if #(
   parameter int WORD_W = 256,
   parameter int ADDR_W = 8,
   parameter int MODE_W = 4
) ();
   localparam int CMD_W = MODE_W + 3 * ADDR_W;

   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr1;
   logic [ADDR_W-1:0] ld_addr2;
   logic [WORD_W-1:0] ld_data1;
   logic [WORD_W-1:0] ld_data2;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [CMD_W-1:0]  cmd_data;

   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] rd_addr1;
   logic [ADDR_W-1:0] rd_addr2;
   logic              rd_rvalid;
   logic [WORD_W-1:0] rd_rdata1;
   logic [WORD_W-1:0] rd_rdata2;

   logic              done;
   logic [MODE_W-1:0] done_mode;
   logic              busy;
   logic              err;

   modport master (
      output ld_valid, ld_addr1, ld_addr2, ld_data1, ld_data2,
      output cmd_valid, cmd_data,
      output rd_valid, rd_addr1, rd_addr2,
      input  ld_ready, cmd_ready, rd_ready,
      input  rd_rvalid, rd_rdata1, rd_rdata2,
      input  done, done_mode, busy, err
   );

   modport slave (
      input  ld_valid, ld_addr1, ld_addr2, ld_data1, ld_data2,
      input  cmd_valid, cmd_data,
      input  rd_valid, rd_addr1, rd_addr2,
      output ld_ready, cmd_ready, rd_ready,
      output rd_rvalid, rd_rdata1, rd_rdata2,
      output done, done_mode, busy, err
   );

endinterface

// File: rtl/calc_drv_arb.sv
// Three-way fixed-priority request arbiter: load > readback > command, gated by en.
module calc_drv_arb (
   input  logic       en,
   input  logic [2:0] req,
   output logic [2:0] gnt
);
   import calc_core_pkg::*;

   // One-hot grant to the highest-priority active request while enabled
   always_comb begin
      gnt = 3'b000;
      if (!en) begin
         gnt = 3'b000;
      end else if (req[REQ_LD]) begin
         gnt = 3'b001;
      end else if (req[REQ_RD]) begin
         gnt = 3'b010;
      end else if (req[REQ_CMD]) begin
         gnt = 3'b100;
      end else begin
         gnt = 3'b000;
      end
   end

endmodule

// File: rtl/calc_core_driver.sv
// Sequences loads, readbacks and commands into the calc core.
// Optional watchdog on EXEC enabled by defining CALC_DRV_TIMEOUT_EN.
module calc_core_driver
   import calc_core_pkg::*;
#(
   parameter int WORD_W = 256,
   parameter int ADDR_W = 8,
   parameter int MODE_W = 4,
   parameter int TO_W   = 16
) (
   input  logic                                clk,
   input  logic                                rst_n,
   calc_core_driver_if.slave                   host,
   output logic [1:0]                          core_inputmode,
   output logic [MODE_W+3*ADDR_W-1:0]          core_cmd,
   output logic [ADDR_W-1:0]                   core_waddr1,
   output logic [ADDR_W-1:0]                   core_waddr2,
   output logic [WORD_W-1:0]                   core_wdata1,
   output logic [WORD_W-1:0]                   core_wdata2,
   output logic [ADDR_W-1:0]                   core_raddr1,
   output logic [ADDR_W-1:0]                   core_raddr2,
   input  logic [WORD_W-1:0]                   core_out1,
   input  logic [WORD_W-1:0]                   core_out2,
   input  logic                                core_finished
);
   localparam int CMD_W    = MODE_W + 3 * ADDR_W;
   localparam int MODE_LSB = cmd_mode_lsb(ADDR_W);

   state_e             state_r;
   state_e             state_s;
   logic               idle_s;
   logic [2:0]         req_s;
   logic [2:0]         gnt_s;
   logic               to_hit_s;
   logic [CMD_W-1:0]   core_cmd_r;
   logic               rd_rvalid_r;
   logic [WORD_W-1:0]  rd_rdata1_r;
   logic [WORD_W-1:0]  rd_rdata2_r;

   assign idle_s = (state_r == ST_IDLE);
   assign req_s  = {host.cmd_valid, host.rd_valid, host.ld_valid};

   calc_drv_arb u_arb (
      .en  (idle_s),
      .req (req_s),
      .gnt (gnt_s)
   );

   assign host.ld_ready  = gnt_s[REQ_LD];
   assign host.rd_ready  = gnt_s[REQ_RD];
   assign host.cmd_ready = gnt_s[REQ_CMD];

`ifdef CALC_DRV_TIMEOUT_EN
   // Watchdog fires on the EXEC cycle in which the count would reach all-ones.
   localparam logic [TO_W-1:0] WDOG_LAST = {{(TO_W-1){1'b1}}, 1'b0};
   logic [TO_W-1:0] wdog_r;
   logic            err_r;

   assign to_hit_s = (state_r == ST_EXEC) && !core_finished && (wdog_r == WDOG_LAST);
   assign host.err = err_r;

   // Watchdog counter and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_r <= {TO_W{1'b0}};
         err_r  <= 1'b0;
      end else begin
         if (gnt_s[REQ_CMD]) begin
            wdog_r <= {TO_W{1'b0}};
         end else if (state_r == ST_EXEC) begin
            wdog_r <= wdog_r + {{(TO_W-1){1'b0}}, 1'b1};
         end else begin
            wdog_r <= wdog_r;
         end
         if (to_hit_s) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
      end
   end
`else
   assign to_hit_s = 1'b0;
   assign host.err = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (gnt_s[REQ_CMD]) state_s = ST_EXEC;
            else                state_s = ST_IDLE;
         end
         ST_EXEC: begin
            if (core_finished || to_hit_s) state_s = ST_REARM;
            else                           state_s = ST_EXEC;
         end
         ST_REARM: state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // Core write/read port steering; addresses and data are zero outside accept cycles
   always_comb begin
      core_inputmode = IM_NOP;
      core_waddr1    = {ADDR_W{1'b0}};
      core_waddr2    = {ADDR_W{1'b0}};
      core_wdata1    = {WORD_W{1'b0}};
      core_wdata2    = {WORD_W{1'b0}};
      core_raddr1    = {ADDR_W{1'b0}};
      core_raddr2    = {ADDR_W{1'b0}};
      if (gnt_s[REQ_LD]) begin
         core_inputmode = IM_INPUT;
         core_waddr1    = host.ld_addr1;
         core_waddr2    = host.ld_addr2;
         core_wdata1    = host.ld_data1;
         core_wdata2    = host.ld_data2;
      end else if (gnt_s[REQ_RD]) begin
         core_inputmode = IM_REF;
         core_raddr1    = host.rd_addr1;
         core_raddr2    = host.rd_addr2;
      end else if (state_r == ST_EXEC) begin
         core_inputmode = IM_EXEC;
      end else begin
         core_inputmode = IM_NOP;
      end
   end

   // State, latched command and readback capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         core_cmd_r  <= {CMD_W{1'b0}};
         rd_rvalid_r <= 1'b0;
         rd_rdata1_r <= {WORD_W{1'b0}};
         rd_rdata2_r <= {WORD_W{1'b0}};
      end else begin
         state_r     <= state_s;
         rd_rvalid_r <= gnt_s[REQ_RD];
         if (gnt_s[REQ_CMD]) begin
            core_cmd_r <= host.cmd_data;
         end else begin
            core_cmd_r <= core_cmd_r;
         end
         if (gnt_s[REQ_RD]) begin
            rd_rdata1_r <= core_out1;
            rd_rdata2_r <= core_out2;
         end else begin
            rd_rdata1_r <= rd_rdata1_r;
            rd_rdata2_r <= rd_rdata2_r;
         end
      end
   end

   assign core_cmd       = core_cmd_r;
   assign host.rd_rvalid = rd_rvalid_r;
   assign host.rd_rdata1 = rd_rdata1_r;
   assign host.rd_rdata2 = rd_rdata2_r;
   assign host.done      = (state_r == ST_REARM);
   assign host.done_mode = core_cmd_r[MODE_LSB +: MODE_W];
   assign host.busy      = !idle_s;

endmodule

// File: tb/tb_calc_core_driver.sv
// Directed testbench for calc_core_driver; honours CALC_DRV_TIMEOUT_EN for the watchdog test.
module tb_calc_core_driver;
   import calc_core_pkg::*;

   localparam int WORD_W = 256;
   localparam int ADDR_W = 8;
   localparam int MODE_W = 4;
`ifdef CALC_DRV_TIMEOUT_EN
   localparam int TO_W = 4;
`else
   localparam int TO_W = 16;
`endif
   localparam int CMD_W = MODE_W + 3 * ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        core_inputmode;
   logic [CMD_W-1:0]  core_cmd;
   logic [ADDR_W-1:0] core_waddr1, core_waddr2, core_raddr1, core_raddr2;
   logic [WORD_W-1:0] core_wdata1, core_wdata2, core_out1, core_out2;
   logic              core_finished;

   int checks = 0;
   int errors = 0;

   calc_core_driver_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .MODE_W(MODE_W)) host ();

   calc_core_driver #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .MODE_W(MODE_W), .TO_W(TO_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .host           (host),
      .core_inputmode (core_inputmode),
      .core_cmd       (core_cmd),
      .core_waddr1    (core_waddr1),
      .core_waddr2    (core_waddr2),
      .core_wdata1    (core_wdata1),
      .core_wdata2    (core_wdata2),
      .core_raddr1    (core_raddr1),
      .core_raddr2    (core_raddr2),
      .core_out1      (core_out1),
      .core_out2      (core_out2),
      .core_finished  (core_finished)
   );

   always #5 clk = ~clk;

   // Core model: read data echoes the read address with a port tag in the low byte
   assign core_out1 = {{(WORD_W-16){1'b0}}, core_raddr1, 8'h11};
   assign core_out2 = {{(WORD_W-16){1'b0}}, core_raddr2, 8'h22};

   task automatic idle_inputs();
      host.ld_valid  = 1'b0; host.ld_addr1 = 8'd0; host.ld_addr2 = 8'd0;
      host.ld_data1  = {WORD_W{1'b0}}; host.ld_data2 = {WORD_W{1'b0}};
      host.cmd_valid = 1'b0; host.cmd_data = {CMD_W{1'b0}};
      host.rd_valid  = 1'b0; host.rd_addr1 = 8'd0; host.rd_addr2 = 8'd0;
      core_finished  = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", host.busy); end
      checks++; if (host.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0h exp=0", host.err); end
      checks++; if (host.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0h exp=0", host.done); end
      checks++; if (core_inputmode !== 2'd0) begin errors++; $display("FAIL reset_inputmode got=%0h exp=0", core_inputmode); end
      checks++; if (core_cmd !== 28'h0) begin errors++; $display("FAIL reset_core_cmd got=%0h exp=0", core_cmd); end
      checks++; if (host.rd_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rd_rvalid got=%0h exp=0", host.rd_rvalid); end
      checks++; if (host.rd_rdata1 !== 256'h0) begin errors++; $display("FAIL reset_rd_rdata1 got=%0h exp=0", host.rd_rdata1); end
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_load();
      next_cycle();
      host.ld_valid = 1'b1; host.ld_addr1 = 8'd3; host.ld_data1 = 256'hA5;
      host.ld_addr2 = 8'd4; host.ld_data2 = 256'h5A;
      @(negedge clk);
      checks++; if (host.ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready got=%0h exp=1", host.ld_ready); end
      checks++; if (core_inputmode !== 2'd1) begin errors++; $display("FAIL load_inputmode got=%0h exp=1", core_inputmode); end
      checks++; if (core_waddr1 !== 8'd3) begin errors++; $display("FAIL load_waddr1 got=%0h exp=3", core_waddr1); end
      checks++; if (core_wdata1 !== 256'hA5) begin errors++; $display("FAIL load_wdata1 got=%0h exp=a5", core_wdata1); end
      checks++; if (core_waddr2 !== 8'd4) begin errors++; $display("FAIL load_waddr2 got=%0h exp=4", core_waddr2); end
      checks++; if (core_wdata2 !== 256'h5A) begin errors++; $display("FAIL load_wdata2 got=%0h exp=5a", core_wdata2); end
      next_cycle();
      host.ld_valid = 1'b0;
      @(negedge clk);
      checks++; if (core_inputmode !== 2'd0) begin errors++; $display("FAIL load_after_mode got=%0h exp=0", core_inputmode); end
      checks++; if (core_waddr1 !== 8'd0 || core_wdata2 !== 256'h0) begin errors++; $display("FAIL load_after_zero got=%0h/%0h exp=0/0", core_waddr1, core_wdata2); end
      checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL load_busy got=%0h exp=0", host.busy); end
   endtask

   task automatic test_cmd_latency();
      logic [CMD_W-1:0] cmd;
      int done_cyc;
      cmd = {4'd2, 8'd1, 8'd2, 8'd3};
      done_cyc = -1;
      next_cycle();
      host.cmd_valid = 1'b1; host.cmd_data = cmd;
      @(negedge clk);
      checks++; if (host.cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready got=%0h exp=1", host.cmd_ready); end
      for (int k = 1; k <= 30; k++) begin
         next_cycle();
         host.cmd_valid = 1'b0;
         core_finished  = (k == 11);
         host.ld_valid  = (k == 5);
         @(negedge clk);
         if (k == 1) begin
            checks++; if (core_cmd !== cmd) begin errors++; $display("FAIL cmd_latched got=%0h exp=%0h", core_cmd, cmd); end
            checks++; if (core_inputmode !== 2'd2) begin errors++; $display("FAIL cmd_exec_mode got=%0h exp=2", core_inputmode); end
            checks++; if (host.busy !== 1'b1) begin errors++; $display("FAIL cmd_busy got=%0h exp=1", host.busy); end
         end
         if (k == 5) begin
            checks++; if (host.ld_ready !== 1'b0 || core_inputmode !== 2'd2) begin errors++; $display("FAIL exec_ld_blocked got=%0h/%0h exp=0/2", host.ld_ready, core_inputmode); end
         end
         if (done_cyc < 0 && host.done === 1'b1) begin
            done_cyc = k;
            checks++; if (host.done_mode !== 4'd2) begin errors++; $display("FAIL cmd_done_mode got=%0h exp=2", host.done_mode); end
         end else if (done_cyc > 0) begin
            checks++; if (host.done !== 1'b0 || host.busy !== 1'b0) begin errors++; $display("FAIL cmd_after_done got=%0h/%0h exp=0/0", host.done, host.busy); end
            checks++; if (core_cmd !== cmd) begin errors++; $display("FAIL cmd_hold got=%0h exp=%0h", core_cmd, cmd); end
            break;
         end
      end
      checks++; if (done_cyc !== 12) begin errors++; $display("FAIL cmd_latency got=%0d exp=12", done_cyc); end
      host.ld_valid = 1'b0;
      // core_finished while idle must not start or complete anything
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         core_finished = 1'b1;
         @(negedge clk);
         checks++; if (host.busy !== 1'b0 || host.done !== 1'b0) begin errors++; $display("FAIL idle_finished got=%0h/%0h exp=0/0", host.busy, host.done); end
      end
      core_finished = 1'b0;
   endtask

   task automatic test_priority_back_to_back();
      logic [CMD_W-1:0] cmd1, cmd2;
      cmd1 = {4'd6, 8'd4, 8'd5, 8'd6};
      cmd2 = {4'd9, 8'd7, 8'd8, 8'd9};
      next_cycle();
      host.ld_valid = 1'b1; host.ld_addr1 = 8'h10; host.ld_data1 = 256'h77;
      host.rd_valid = 1'b1; host.rd_addr1 = 8'd7; host.rd_addr2 = 8'd9;
      host.cmd_valid = 1'b1; host.cmd_data = cmd1;
      @(negedge clk);
      checks++; if ({host.ld_ready, host.rd_ready, host.cmd_ready} !== 3'b100) begin errors++; $display("FAIL prio_c1 got=%b exp=100", {host.ld_ready, host.rd_ready, host.cmd_ready}); end
      checks++; if (core_inputmode !== 2'd1 || core_raddr1 !== 8'd0) begin errors++; $display("FAIL prio_c1_port got=%0h/%0h exp=1/0", core_inputmode, core_raddr1); end
      next_cycle();
      host.ld_valid = 1'b0;
      @(negedge clk);
      checks++; if ({host.ld_ready, host.rd_ready, host.cmd_ready} !== 3'b010) begin errors++; $display("FAIL prio_c2 got=%b exp=010", {host.ld_ready, host.rd_ready, host.cmd_ready}); end
      checks++; if (core_inputmode !== 2'd3 || core_raddr1 !== 8'd7 || core_raddr2 !== 8'd9) begin errors++; $display("FAIL prio_c2_port got=%0h/%0h/%0h exp=3/7/9", core_inputmode, core_raddr1, core_raddr2); end
      checks++; if (host.rd_rvalid !== 1'b0) begin errors++; $display("FAIL prio_c2_rvalid got=%0h exp=0", host.rd_rvalid); end
      next_cycle();
      host.rd_valid = 1'b0;
      @(negedge clk);
      checks++; if ({host.ld_ready, host.rd_ready, host.cmd_ready} !== 3'b001) begin errors++; $display("FAIL prio_c3 got=%b exp=001", {host.ld_ready, host.rd_ready, host.cmd_ready}); end
      checks++; if (host.rd_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid got=%0h exp=1", host.rd_rvalid); end
      checks++; if (host.rd_rdata1 !== 256'h0711) begin errors++; $display("FAIL rd_rdata1 got=%0h exp=711", host.rd_rdata1); end
      checks++; if (host.rd_rdata2 !== 256'h0922) begin errors++; $display("FAIL rd_rdata2 got=%0h exp=922", host.rd_rdata2); end
      checks++; if (core_raddr1 !== 8'd0) begin errors++; $display("FAIL rd_raddr_zero got=%0h exp=0", core_raddr1); end
      next_cycle();
      host.cmd_valid = 1'b0; core_finished = 1'b1;
      @(negedge clk);
      checks++; if (host.rd_rvalid !== 1'b0 || host.busy !== 1'b1) begin errors++; $display("FAIL rvalid_one_cycle got=%0h/%0h exp=0/1", host.rd_rvalid, host.busy); end
      checks++; if (core_cmd !== cmd1) begin errors++; $display("FAIL prio_cmd got=%0h exp=%0h", core_cmd, cmd1); end
      next_cycle();
      core_finished = 1'b0; host.cmd_valid = 1'b1; host.cmd_data = cmd2;
      @(negedge clk);
      checks++; if (host.done !== 1'b1 || host.done_mode !== 4'd6) begin errors++; $display("FAIL b2b_done1 got=%0h/%0h exp=1/6", host.done, host.done_mode); end
      checks++; if (host.cmd_ready !== 1'b0 || core_inputmode !== 2'd0) begin errors++; $display("FAIL rearm_blocks got=%0h/%0h exp=0/0", host.cmd_ready, core_inputmode); end
      next_cycle();
      @(negedge clk);
      checks++; if (host.done !== 1'b0 || host.busy !== 1'b0 || host.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got=%0h/%0h/%0h exp=0/0/1", host.done, host.busy, host.cmd_ready); end
      next_cycle();
      host.cmd_valid = 1'b0; core_finished = 1'b1;
      @(negedge clk);
      checks++; if (host.busy !== 1'b1 || core_cmd !== cmd2) begin errors++; $display("FAIL b2b_cmd2 got=%0h/%0h exp=1/%0h", host.busy, core_cmd, cmd2); end
      next_cycle();
      core_finished = 1'b0;
      @(negedge clk);
      checks++; if (host.done !== 1'b1 || host.done_mode !== 4'd9) begin errors++; $display("FAIL b2b_done2 got=%0h/%0h exp=1/9", host.done, host.done_mode); end
      next_cycle();
      @(negedge clk);
      checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy got=%0h exp=0", host.busy); end
   endtask

   task automatic test_reset_mid_exec();
      int done_cyc;
      next_cycle();
      host.cmd_valid = 1'b1; host.cmd_data = {4'd5, 8'd1, 8'd1, 8'd1};
      repeat (3) begin
         next_cycle();
         host.cmd_valid = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      checks++; if (host.busy !== 1'b0 || host.done !== 1'b0 || host.err !== 1'b0) begin errors++; $display("FAIL mid_rst_status got=%0h/%0h/%0h exp=0/0/0", host.busy, host.done, host.err); end
      checks++; if (core_cmd !== 28'h0 || core_inputmode !== 2'd0) begin errors++; $display("FAIL mid_rst_core got=%0h/%0h exp=0/0", core_cmd, core_inputmode); end
      checks++; if (host.rd_rdata1 !== 256'h0 || host.rd_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_rd got=%0h/%0h exp=0/0", host.rd_rdata1, host.rd_rvalid); end
      next_cycle();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         core_finished = (k == 1);
         @(negedge clk);
         checks++; if (host.done !== 1'b0 || host.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_no_done got=%0h/%0h exp=0/0", host.done, host.busy); end
      end
      next_cycle();
      core_finished = 1'b0; host.cmd_valid = 1'b1; host.cmd_data = {4'd5, 8'd2, 8'd2, 8'd2};
      done_cyc = -1;
      for (int k = 1; k <= 20; k++) begin
         next_cycle();
         host.cmd_valid = 1'b0;
         core_finished = (k == 3);
         @(negedge clk);
         if (host.done === 1'b1) begin
            done_cyc = k;
            checks++; if (host.done_mode !== 4'd5) begin errors++; $display("FAIL post_rst_mode got=%0h exp=5", host.done_mode); end
            break;
         end
      end
      checks++; if (done_cyc !== 4) begin errors++; $display("FAIL post_rst_latency got=%0d exp=4", done_cyc); end
      next_cycle();
      core_finished = 1'b0;
   endtask

   task automatic test_timeout();
`ifdef CALC_DRV_TIMEOUT_EN
      int done_cyc;
      done_cyc = -1;
      next_cycle();
      host.cmd_valid = 1'b1; host.cmd_data = {4'd3, 8'd0, 8'd0, 8'd0};
      for (int k = 1; k <= 40; k++) begin
         next_cycle();
         host.cmd_valid = 1'b0;
         @(negedge clk);
         if (k == 15) begin
            checks++; if (host.err !== 1'b0 || host.busy !== 1'b1) begin errors++; $display("FAIL to_pre got=%0h/%0h exp=0/1", host.err, host.busy); end
         end
         if (host.done === 1'b1) begin
            done_cyc = k;
            checks++; if (host.err !== 1'b1 || host.done_mode !== 4'd3) begin errors++; $display("FAIL to_done got=%0h/%0h exp=1/3", host.err, host.done_mode); end
            break;
         end
      end
      checks++; if (done_cyc !== 16) begin errors++; $display("FAIL to_latency got=%0d exp=16", done_cyc); end
      next_cycle();
      @(negedge clk);
      checks++; if (host.err !== 1'b1 || host.busy !== 1'b0) begin errors++; $display("FAIL to_sticky got=%0h/%0h exp=1/0", host.err, host.busy); end
`else
      next_cycle();
      host.cmd_valid = 1'b1; host.cmd_data = {4'd3, 8'd0, 8'd0, 8'd0};
      for (int k = 1; k <= 40; k++) begin
         next_cycle();
         host.cmd_valid = 1'b0;
         @(negedge clk);
         checks++; if (host.busy !== 1'b1 || host.done !== 1'b0 || host.err !== 1'b0) begin errors++; $display("FAIL no_to_wait k=%0d got=%0h/%0h/%0h exp=1/0/0", k, host.busy, host.done, host.err); end
      end
      next_cycle();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (host.busy !== 1'b0) begin errors++; $display("FAIL no_to_exit got=%0h exp=0", host.busy); end
`endif
   endtask

   initial begin
      test_reset();
      test_load();
      test_cmd_latency();
      test_priority_back_to_back();
      test_reset_mid_exec();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL sim_timeout got=running exp=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/calc_core_driver.md
CALC_CORE_DRIVER -- requirements
Module: calc_core_driver

Interface
REQ-001 SHALL have parameters: WORD_W, 256, operand word width; ADDR_W, 8, core RAM address width; MODE_W, 4, command mode field width; TO_W, 16, watchdog counter width.
REQ-002 SHALL derive CMD_W = MODE_W + 3*ADDR_W as a localparam, laid out {mode, opr1_addr, opr2_addr, ret_addr}, MSB first.
REQ-003 SHALL use reset rst_n, asynchronous, active-low; clock clk.
REQ-004 clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-005 ld_valid  in  1  load request; ld_ready  out  1  load accepted this cycle.
REQ-006 ld_addr1, ld_addr2  in  ADDR_W  write addresses; ld_data1, ld_data2  in  WORD_W  write data.
REQ-007 cmd_valid  in  1  command request; cmd_ready  out  1  command accepted; cmd_data  in  CMD_W  command.
REQ-008 rd_valid  in  1  readback request; rd_ready  out  1  accepted; rd_addr1, rd_addr2  in  ADDR_W.
REQ-009 rd_rvalid  out  1  readback data valid; rd_rdata1, rd_rdata2  out  WORD_W.
REQ-010 done  out  1  one-cycle command-complete pulse; done_mode  out  MODE_W  mode of completed command.
REQ-011 busy  out  1  high outside IDLE; err  out  1  sticky watchdog error.
REQ-012 core_inputmode  out  2; core_cmd  out  CMD_W; core_waddr1/2  out  ADDR_W; core_wdata1/2  out  WORD_W; core_raddr1/2  out  ADDR_W; core_out1/2  in  WORD_W; core_finished  in  1.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, REARM; core_inputmode = INPUT while a load is accepted, REF while a readback is accepted, EXEC in EXEC, NOP in IDLE/REARM.
REQ-014 In IDLE, SHALL accept at most one request per cycle, priority load > readback > command; ready asserted combinationally only to the winner, only in IDLE.
REQ-015 Load accept SHALL drive core_waddr*/core_wdata* from ld_* in that cycle (one-cycle write, both ports); FSM stays IDLE.
REQ-016 Readback accept SHALL drive core_raddr* from rd_addr*, register core_out* at that edge, and assert rd_rvalid for exactly the next cycle with the registered data.
REQ-017 Command accept SHALL latch cmd_data into core_cmd and enter EXEC next cycle; core_cmd SHALL stay constant until next accept.
REQ-018 In EXEC, core_finished sampled high SHALL move FSM to REARM; core_finished in any other state SHALL be ignored.
REQ-019 REARM SHALL last exactly one cycle with core_inputmode NOP, assert done with done_mode = core_cmd mode field, then return to IDLE.
REQ-020 Command-to-done latency SHALL be (cycles until core_finished) + 2; back-to-back commands SHALL be separated by at least one IDLE cycle.
REQ-021 core_waddr*/core_wdata*/core_raddr* SHALL be driven 0 when not in an accepting cycle.

Reset
REQ-022 On rst_n low, at any point including mid-EXEC: FSM IDLE, core_inputmode NOP, core_cmd 0, done 0, done_mode 0, rd_rvalid 0, rd_rdata* 0, busy 0, err 0, watchdog 0; no done issued for aborted command.

Configuration
REQ-023 With CALC_DRV_TIMEOUT_EN defined, a TO_W-bit counter SHALL clear on EXEC entry, increment each EXEC cycle, and on reaching all-ones SHALL set err, go to REARM, and issue done.
REQ-024 Without CALC_DRV_TIMEOUT_EN, EXEC SHALL wait indefinitely, err tied 0, no counter flops.

Structure
REQ-025 Input-mode encodings (NOP=0, INPUT=1, EXEC=2, REF=3), FSM state encoding and CMD field offsets SHALL live in shared package calc_core_pkg.
REQ-026 Request arbitration SHALL be a sub-module calc_drv_arb (3-way fixed priority, combinational); no other sub-modules.

Verification
REQ-027 Load ld_addr1=3, ld_data1=0xA5, ld_addr2=4, ld_data2=0x5A -> single cycle core_inputmode=1, core_waddr1=3, core_wdata2=0x5A, ld_ready=1.
REQ-028 cmd_data mode=2, core_finished raised 10 cycles after EXEC entry -> done pulse one cycle after finished sample, done_mode=2, total latency 12.
REQ-029 ld_valid, rd_valid, cmd_valid all high in IDLE -> ld accepted cycle 1, rd cycle 2, cmd cycle 3; rd_rvalid one cycle after rd accept with core_out values.
REQ-030 rst_n pulsed low during EXEC -> all outputs reset values, no done, next cmd accepted normally.
REQ-031 With CALC_DRV_TIMEOUT_EN, TO_W=4, core_finished held 0 -> err=1 and done after 15 EXEC cycles; without macro, busy stays 1.
